button_matrix_scanner: RTL
==========================

# button_matrix_scanner

Active scanner for an R×C push-button matrix. It drives one column at a time, samples the row lines through a two-flop synchronizer, and assembles a full-matrix frame. It debounces the frame result over several consecutive frames and delivers each debounced key press as a linear index on a valid/ready interface. It sits between the keypad pins and the game controller, and replaces the combinational one-hot-to-index decoder with a clocked, self-scanning, debounced block.

## Interface
Parameters:
- ROWS, 4: number of row lines (≥1).
- COLS, 4: number of column lines (≥1).
- SCAN_DIV, 1000: clock cycles each column is driven (≥4).
- DEBOUNCE, 4: consecutive identical frames needed to accept a change (≥1).
- IDX_W, $clog2(ROWS*COLS) (minimum 1): derived; do not override.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- col_drive  out  COLS  one-hot active-high column strobe.
- row_in  in  ROWS  raw asynchronous row sense; bit r high means a key in row r of the driven column is closed.
- key_valid  out  1  press event available.
- key_idx  out  IDX_W  index of the pressed key: row*COLS + col.
- key_ready  in  1  consumer accepts the event.
- key_down  out  1  level: a debounced key is currently held.
- overrun  out  1  one-cycle pulse: an event was dropped.

## Operation
- **Synchronizer:** row_in passes through two flops, giving row_s.
- **Scan:**
  - col counter 0..COLS-1; dwell counter 0..SCAN_DIV-1.
  - col_drive = 1<<col.
  - On dwell == SCAN_DIV-1: frame_buf[r*COLS+col] <= row_s[r] for all r. Then dwell wraps to 0 and col advances, wrapping COLS-1 -> 0.
  - The cycle that samples col COLS-1 is end-of-frame (EOF).
- **Candidate (at EOF):** the lowest set index of the completed frame, or NONE if the frame is all zero. The column COLS-1 bits come from the same-cycle sample. Multiple pressed keys: the lowest index wins.
- **Debounce (at EOF):**
  - If cand == prev_cand, then cnt = min(cnt+1, DEBOUNCE); otherwise cnt = 1.
  - prev_cand <= cand.
  - If the new cnt == DEBOUNCE and cand != stable: stable <= cand.
  - If that new stable is a key (not NONE), a press event fires with idx = cand.
  - A transition to NONE (release) updates stable only; no event.
  - A direct change A->B fires an event for B.
- **key_down** = (stable != NONE).
- **Output register (single entry):**
  - Event with key_valid=0: load key_idx and set key_valid.
  - Event with key_valid=1 and key_ready=1: load the new idx; key_valid stays 1.
  - Event with key_valid=1 and key_ready=0: drop the event; key_idx unchanged; overrun=1 for that cycle.
  - No event with key_valid & key_ready: clear key_valid.
- **key_idx** is held stable while key_valid=1 and not accepted.

## Timing
- Reset values:
  - col_drive = 1 (column 0), key_valid = 0, key_idx = 0, key_down = 0, overrun = 0.
  - Synchronizer, frame_buf, dwell, col, cnt = 0.
  - prev_cand = stable = NONE.
- Frame period is exactly COLS*SCAN_DIV cycles; the first EOF is at cycle COLS*SCAN_DIV-1 after reset release.
- Row sample latency: row_in must be stable by dwell == SCAN_DIV-3 to be captured (2-cycle synchronizer).
- Press latency: a key held from before frame k's first cycle gets its event on EOF of frame k+DEBOUNCE-1. key_valid, key_idx and key_down rise on the next cycle.
- key_down falls one cycle after the EOF that accepts NONE.
- Asserting rst_n low at any point returns everything to reset values immediately. Scanning restarts at column 0, dwell 0, and any pending event is lost.

## Test plan
Bench parameters: ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE=3 (frame = 32 cycles).
1. **Reset:** hold rst_n=0 for 5 cycles, then release -> col_drive=4'b0001 with the column advancing every 8 cycles (0001, 0010, 0100, 1000, 0001). key_valid=0, key_down=0, overrun=0 throughout with row_in=0.
2. **Single press:** model row 2 closed whenever col 1 is driven, from reset release, with key_ready=1 -> key_valid pulses exactly once, for 1 cycle, at cycle 96 with key_idx=9. key_down is 1 from cycle 96. Remove the key -> key_down falls 3 frames later; no second event.
3. **Bounce:** key 9 present in alternate frames for 10 frames -> key_valid never asserts and key_down stays 0.
4. **Multi-key and change:** keys 5 and 10 held -> one event with idx 5. Then release 5 while still holding 10 -> after 3 frames a second event with idx 10.
5. **Backpressure:** key_ready=0. Press 9 (accepted), release, then press 3 -> key_idx stays 9, key_valid stays 1, and overrun pulses one cycle at the EOF accepting 3. Assert key_ready=1 -> key_valid drops the next cycle.
6. **Reset mid-operation:** with key 9 held and cnt=2, pulse rst_n low mid-dwell -> outputs return to reset values. The event then fires 3 full frames after the release of reset, not earlier.

Source files
------------

// File: rtl/button_matrix_scanner.sv
// Self-scanning, debounced R x C push-button matrix scanner.
// Drives one column at a time, samples the rows through a two-flop
// synchronizer, assembles a full frame, debounces the lowest pressed key
// over consecutive frames, and hands each accepted press to a single-entry
// valid/ready output register.
module button_matrix_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  parameter int IDX_W    = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [COLS-1:0]  col_drive,
  input  logic [ROWS-1:0]  row_in,
  output logic             key_valid,
  output logic [IDX_W-1:0] key_idx,
  input  logic             key_ready,
  output logic             key_down,
  output logic             overrun
);

  localparam int NKEYS   = ROWS * COLS;
  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam int CNT_W   = $clog2(DEBOUNCE + 1);

  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(DEBOUNCE);

  // A key slot: either NONE (no key) or a linear index. idx is kept at zero
  // whenever none is set so that plain equality compares keys correctly.
  typedef struct packed {
    logic             none;
    logic [IDX_W-1:0] idx;
  } key_t;

  localparam key_t KEY_NONE = {1'b1, {IDX_W{1'b0}}};

  logic [ROWS-1:0]    row_meta;
  logic [ROWS-1:0]    row_s;
  logic [COL_W-1:0]   col;
  logic [DWELL_W-1:0] dwell;
  logic               dwell_end;
  logic               eof;
  logic [NKEYS-1:0]   frame_buf;
  logic [NKEYS-1:0]   frame_next;
  key_t               cand;
  key_t               prev_cand;
  key_t               stable;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               accept;
  logic               press;

  assign dwell_end = (dwell == DWELL_LAST);
  assign eof       = dwell_end && (col == COL_LAST);

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= '0;
      row_s    <= '0;
    end else begin
      row_meta <= row_in;
      row_s    <= row_meta;
    end
  end

  // Column dwell timer and column pointer; column advances when the dwell wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell <= '0;
      col   <= '0;
    end else if (dwell_end) begin
      dwell <= '0;
      col   <= (col == COL_LAST) ? '0 : col + COL_W'(1);
    end else begin
      dwell <= dwell + DWELL_W'(1);
    end
  end

  // One-hot column strobe decoded from the column pointer.
  always_comb begin
    col_drive = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col == COL_W'(c)) col_drive[c] = 1'b1;
    end
  end

  // Frame contents including this cycle's sample, so EOF sees the last column.
  always_comb begin
    frame_next = frame_buf;
    for (int c = 0; c < COLS; c++) begin
      if (dwell_end && (col == COL_W'(c))) begin
        for (int r = 0; r < ROWS; r++) frame_next[r * COLS + c] = row_s[r];
      end
    end
  end

  // Frame buffer holds the most recent sample of every key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_buf <= '0;
    else        frame_buf <= frame_next;
  end

  // Lowest set index of the frame wins; scan downward so lower indices override.
  always_comb begin
    cand = KEY_NONE;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (frame_next[i]) begin
        cand.none = 1'b0;
        cand.idx  = IDX_W'(i);
      end
    end
  end

  // Saturating run-length of identical candidates and the acceptance decision.
  always_comb begin
    if (cand != prev_cand)    cnt_next = CNT_W'(1);
    else if (cnt == CNT_MAX)  cnt_next = CNT_MAX;
    else                      cnt_next = cnt + CNT_W'(1);
    accept = (cnt_next == CNT_MAX) && (cand != stable);
    press  = eof && accept && !cand.none;
  end

  // Debounce state advances once per frame, at end-of-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      prev_cand <= KEY_NONE;
      stable    <= KEY_NONE;
    end else if (eof) begin
      cnt       <= cnt_next;
      prev_cand <= cand;
      if (accept) stable <= cand;
    end
  end

  assign key_down = !stable.none;

  // Single-entry event register; a press arriving while the entry is held
  // without acceptance is dropped and flagged on overrun for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_idx   <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (press) begin
        if (!key_valid || key_ready) begin
          key_valid <= 1'b1;
          key_idx   <= cand.idx;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule
